// File: rtl/clk_sched_pkg.sv
// Shared constants and channel state type for the programmable two-channel
// sysclk divider (motor and controller clock/tick generators).
package clk_sched_pkg;

    localparam int CNT_W = 24;

    localparam logic [CNT_W-1:0] DIV_M_RST = 24'd6000000;
    localparam logic [CNT_W-1:0] DIV_C_RST = 24'd6000;

    localparam logic CH_MOTOR = 1'b0;
    localparam logic CH_CTRL  = 1'b1;

    typedef enum logic [1:0] {
        STOP     = 2'd0,
        RUN      = 2'd1,
        RUN_PEND = 2'd2
    } ch_state_e;

endpackage

// File: rtl/div_channel.sv
// One divider channel: counts sysclk cycles up to the active divisor, toggles
// a square clock with a matching one-cycle tick, and holds at most one pending divisor.
module div_channel #(
    parameter int               CNT_W   = clk_sched_pkg::CNT_W,
    parameter logic [CNT_W-1:0] DIV_RST = clk_sched_pkg::DIV_M_RST
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pend,
    output logic             ch_clk,
    output logic             ch_tick
);
    import clk_sched_pkg::*;

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pdiv_q, pdiv_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             terminal;
    logic [CNT_W-1:0] wr_val;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOP;
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            pdiv_q  <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        pdiv_d   = pdiv_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        terminal = (cnt_q == div_q);
        // A zero divisor would give a one-cycle half-period; clamp to keep it >= 2 cycles.
        wr_val   = (wr_div == '0) ? CNT_W'(1) : wr_div;

        if (!run) begin
            state_d = STOP;
            cnt_d   = '0;
            clk_d   = 1'b0;
            if (state_q == RUN_PEND) begin
                div_d = pdiv_q;
            end else if (wr_en) begin
                div_d = wr_val;
            end
        end else if (state_q == STOP) begin
            state_d = RUN;
            cnt_d   = '0;
            clk_d   = 1'b0;
            if (wr_en) begin
                div_d = wr_val;
            end
        end else begin
            if (terminal) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                if (state_q == RUN_PEND) begin
                    div_d   = pdiv_q;
                    state_d = RUN;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Evaluated after the terminal check so a write on the terminal cycle waits a full half-period.
            if (wr_en && state_q == RUN) begin
                pdiv_d  = wr_val;
                state_d = RUN_PEND;
            end
        end
    end

    assign pend    = (state_q == RUN_PEND);
    assign ch_clk  = clk_q;
    assign ch_tick = tick_q;

endmodule

// File: rtl/clk_enable_scheduler.sv
// Two independent run-time programmable clock/tick generators (motor, controller)
// with a shared valid/ready divisor configuration port.
module clk_enable_scheduler #(
    parameter int               CNT_W     = clk_sched_pkg::CNT_W,
    parameter logic [CNT_W-1:0] DIV_M_RST = clk_sched_pkg::DIV_M_RST,
    parameter logic [CNT_W-1:0] DIV_C_RST = clk_sched_pkg::DIV_C_RST
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic             cfg_sel,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic [1:0]       cfg_pending,
    output logic             m_clk,
    output logic             m_tick,
    output logic             c_clk,
    output logic             c_tick
);
    import clk_sched_pkg::*;

    logic [1:0] pend;
    logic       wr_m;
    logic       wr_c;

    // A channel refuses a new divisor until its held one has been committed.
    assign cfg_ready   = ~pend[cfg_sel];
    assign wr_m        = cfg_valid & cfg_ready & (cfg_sel == CH_MOTOR);
    assign wr_c        = cfg_valid & cfg_ready & (cfg_sel == CH_CTRL);
    assign cfg_pending = pend;

    div_channel #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_M_RST)
    ) u_motor (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .run     (run),
        .wr_en   (wr_m),
        .wr_div  (cfg_div),
        .pend    (pend[0]),
        .ch_clk  (m_clk),
        .ch_tick (m_tick)
    );

    div_channel #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_C_RST)
    ) u_ctrl (
        .sysclk  (sysclk),
        .rst_n   (rst_n),
        .run     (run),
        .wr_en   (wr_c),
        .wr_div  (cfg_div),
        .pend    (pend[1]),
        .ch_clk  (c_clk),
        .ch_tick (c_tick)
    );

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Randomised scoreboard bench for clk_enable_scheduler: a per-channel event-time
// model predicts every cycle's outputs, a monitor compares them on the falling edge.
module tb_clk_enable_scheduler;

    localparam int CNT_W = 24;
    localparam int M_RST = 6000000;
    localparam int C_RST = 3;

    logic             sysclk;
    logic             rst_n;
    logic             run;
    logic             cfg_valid;
    logic             cfg_sel;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic [1:0]       cfg_pending;
    logic             m_clk;
    logic             m_tick;
    logic             c_clk;
    logic             c_tick;

    int n_compared;
    int n_mismatched;

    // Channel model in terms of time-to-next-toggle rather than a counter.
    typedef struct {
        bit running;
        int active;
        bit pend;
        int pend_val;
        bit clk;
        bit tick;
        int remaining;
    } ch_model_t;

    typedef struct {
        logic       m_clk;
        logic       m_tick;
        logic       c_clk;
        logic       c_tick;
        logic [1:0] pending;
        logic       ready;
    } exp_t;

    ch_model_t mdl [2];
    exp_t      exp_q [$];

    clk_enable_scheduler #(
        .DIV_C_RST (24'd3)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_sel     (cfg_sel),
        .cfg_div     (cfg_div),
        .cfg_ready   (cfg_ready),
        .cfg_pending (cfg_pending),
        .m_clk       (m_clk),
        .m_tick      (m_tick),
        .c_clk       (c_clk),
        .c_tick      (c_tick)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int ch = 0; ch < 2; ch++) begin
            mdl[ch].running   = 1'b0;
            mdl[ch].active    = (ch == 0) ? M_RST : C_RST;
            mdl[ch].pend      = 1'b0;
            mdl[ch].pend_val  = 0;
            mdl[ch].clk       = 1'b0;
            mdl[ch].tick      = 1'b0;
            mdl[ch].remaining = 0;
        end
    endtask

    // Advances one channel across one sysclk edge given the inputs sampled there.
    task automatic modelEdge(input int ch, input bit r, input bit wr, input int d);
        int v;
        v = (d == 0) ? 1 : d;
        if (!r) begin
            mdl[ch].running = 1'b0;
            mdl[ch].clk     = 1'b0;
            mdl[ch].tick    = 1'b0;
            if (mdl[ch].pend) begin
                mdl[ch].active = mdl[ch].pend_val;
                mdl[ch].pend   = 1'b0;
            end else if (wr) begin
                mdl[ch].active = v;
            end
        end else if (!mdl[ch].running) begin
            mdl[ch].running   = 1'b1;
            mdl[ch].clk       = 1'b0;
            mdl[ch].tick      = 1'b0;
            if (wr) mdl[ch].active = v;
            mdl[ch].remaining = mdl[ch].active + 1;
        end else begin
            mdl[ch].remaining--;
            mdl[ch].tick = 1'b0;
            if (mdl[ch].remaining == 0) begin
                mdl[ch].clk  = ~mdl[ch].clk;
                mdl[ch].tick = 1'b1;
                if (mdl[ch].pend) begin
                    mdl[ch].active = mdl[ch].pend_val;
                    mdl[ch].pend   = 1'b0;
                end
                mdl[ch].remaining = mdl[ch].active + 1;
            end
            if (wr) begin
                mdl[ch].pend     = 1'b1;
                mdl[ch].pend_val = v;
            end
        end
    endtask

    // Drives one cycle of inputs, queues the outputs expected for that cycle, then steps the model.
    task automatic applyStimulus(input bit r, input bit v, input bit s, input int d);
        exp_t e;
        bit   rdy;
        @(posedge sysclk);
        #1;
        if (!rst_n) rst_n = 1'b1;
        run       = r;
        cfg_valid = v;
        cfg_sel   = s;
        cfg_div   = CNT_W'(d);
        rdy       = ~mdl[s].pend;
        e.m_clk   = mdl[0].clk;
        e.m_tick  = mdl[0].tick;
        e.c_clk   = mdl[1].clk;
        e.c_tick  = mdl[1].tick;
        e.pending = {mdl[1].pend, mdl[0].pend};
        e.ready   = rdy;
        exp_q.push_back(e);
        modelEdge(0, r, v && rdy && (s == 1'b0), d);
        modelEdge(1, r, v && rdy && (s == 1'b1), d);
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for sysclk.
    task automatic resetPulse();
        @(negedge sysclk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_m_clk", int'(m_clk), 0);
        checkOutput("rst_m_tick", int'(m_tick), 0);
        checkOutput("rst_c_clk", int'(c_clk), 0);
        checkOutput("rst_c_tick", int'(c_tick), 0);
        checkOutput("rst_pending", int'(cfg_pending), 0);
        checkOutput("rst_ready", int'(cfg_ready), 1);
        modelReset();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge sysclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("m_clk", int'(m_clk), int'(e.m_clk));
                checkOutput("m_tick", int'(m_tick), int'(e.m_tick));
                checkOutput("c_clk", int'(c_clk), int'(e.c_clk));
                checkOutput("c_tick", int'(c_tick), int'(e.c_tick));
                checkOutput("cfg_pending", int'(cfg_pending), int'(e.pending));
                checkOutput("cfg_ready", int'(cfg_ready), int'(e.ready));
            end
        end
    end

    initial begin
        int  guard;
        bit  r;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b1;
        run          = 1'b0;
        cfg_valid    = 1'b0;
        cfg_sel      = 1'b0;
        cfg_div      = '0;
        modelReset();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("init_m_clk", int'(m_clk), 0);
        checkOutput("init_c_clk", int'(c_clk), 0);
        checkOutput("init_pending", int'(cfg_pending), 0);
        checkOutput("init_ready", int'(cfg_ready), 1);

        $display("[TB] free-running controller channel at reset divisor");
        for (int i = 0; i < 24; i++) applyStimulus(1, 0, 0, 0);

        $display("[TB] mid-half-period write to controller channel");
        applyStimulus(1, 1, 1, 1);
        for (int i = 0; i < 14; i++) applyStimulus(1, 0, 1, 0);

        $display("[TB] write landing on the terminal cycle");
        guard = 0;
        while (!(mdl[1].running && !mdl[1].pend && mdl[1].remaining == 1) && guard < 50) begin
            applyStimulus(1, 0, 0, 0);
            guard++;
        end
        if (guard >= 50) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL terminal_wait: got no terminal cycle, expected one within 50 cycles");
        end
        applyStimulus(1, 1, 1, 3);
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1, 0);

        $display("[TB] second write while pending, other channel still accepts");
        applyStimulus(1, 1, 1, 5);
        applyStimulus(1, 1, 1, 2);
        applyStimulus(1, 1, 0, 2);
        applyStimulus(1, 1, 0, 7);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0);

        $display("[TB] stop with pending, zero divisor clamp, restart");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0);

        $display("[TB] asynchronous reset mid-count");
        applyStimulus(1, 1, 1, 4);
        applyStimulus(1, 0, 0, 0);
        resetPulse();
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);

        $display("[TB] randomised traffic");
        r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) r = ~r;
            if ($urandom_range(0, 599) == 0) resetPulse();
            applyStimulus(r, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 6)));
        end
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);

        @(negedge sysclk);
        #2;
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
